vic_bus_arbiter: RTL
====================

# vic_bus_arbiter

Phase sequencer and bus arbiter for the shared 14-bit video bus, 12-bit colour/screen RAM and character ROM. It time-multiplexes the bus between the VIC-II (phi0 low half) and the CPU (phi0 high half). It also implements VIC cycle stealing: BA warning, the 3-cycle write grace period, then AEC held low. It generates phi0, aec and ba, and replaces the ad-hoc `aec ? cpu_addr : vic_aout` muxing done around the video memory.

## Interface
- ADDR_WIDTH, 14, bus address width
- DATA_WIDTH, 12, bus data width (4-bit colour nibble + 8-bit data)
- PHASES, 8, pixel clocks per phi0 cycle; must be even, ≥ 4
- clk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- vic_req  in  1  VIC requests both bus halves (badline / sprite DMA)
- vic_addr  in  ADDR_WIDTH  VIC address for the phi0-low half
- vic_rdata  out  DATA_WIDTH  data captured for the VIC
- cpu_req  in  1  CPU access pending; held until cpu_ack
- cpu_we  in  1  1 = write
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_rdata  out  DATA_WIDTH  captured read data
- cpu_ack  out  1  one-clock pulse when the CPU access completes
- phi0  out  1  system phase; high in the second half-cycle
- aec  out  1  1 = CPU drives bus
- ba  out  1  0 = VIC bus request warning (CPU RDY)
- mem_addr  out  ADDR_WIDTH  muxed bus address
- mem_we  out  1  RAM write strobe
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  synchronous RAM/ROM read data, 1-clock latency

## Operation
- Phase counter `ph` runs 0..PHASES-1 and wraps. H = PHASES/2. phi0 = (ph ≥ H).
- First half (ph < H): always a VIC slot. mem_addr = vic_addr. vic_rdata is captured from mem_rdata at ph = H-1.
- Second half: owned by the CPU unless the state is STOLEN. In that case mem_addr = vic_addr and vic_rdata is also captured at ph = PHASES-1.
- aec = phi0 && state ≠ STOLEN.
- State machine. Transitions are evaluated only at ph = 0, with vic_req sampled in that clock.
  - IDLE: ba=1. If vic_req = 1 → BA_WAIT, grace count = 3.
  - BA_WAIT: ba=0.
    - If vic_req = 0 → IDLE.
    - Otherwise decrement the grace count; at 0 → STOLEN.
    - Net effect: 3 CPU half-cycles remain in the same cycle as the ba fall plus the next 2.
  - STOLEN: ba=0, aec=0 for the whole cycle. If vic_req = 0 → IDLE; aec returns in that same cycle's second half.
- CPU access in a granted half (aec=1):
  - Write: mem_we=1 for ph = H only.
  - Read: cpu_rdata captured at ph = PHASES-1.
  - cpu_ack pulses at ph = PHASES-1 in both cases.
- In BA_WAIT, only writes are granted. Reads stall: no ack, request held, bus still driven with cpu_addr, mem_we=0. This matches 6510 RDY semantics.
- In STOLEN, no CPU access is granted and mem_we is forced 0.
- If cpu_req = 0 in a granted half, mem_addr = cpu_addr and mem_we = 0.

## Timing
- Reset values: ph=0, state IDLE, phi0=0, aec=0, ba=1, mem_we=0, cpu_ack=0, cpu_rdata=0, vic_rdata=0, mem_addr=vic_addr (combinational).
- phi0, aec, ba and mem_we are registered, so they change on the clk edge entering the phase.
- mem_addr is combinational from phase and state, with no extra latency.
- Read latency is fixed: the address must be stable ≥ 2 clocks before capture.
- Reset asserted mid-cycle: all outputs return to reset values on the next edge. The in-flight CPU access is dropped without ack and without a partial write.
- vic_req toggling between ph = 0 samples is ignored.

## Structure
- Shared package `c64_bus_pkg`:
  - state enum {IDLE, BA_WAIT, STOLEN}
  - BA_GRACE = 3
  - default ADDR_WIDTH / DATA_WIDTH
- Sub-module `phi_phase_gen`: the phase counter plus phi0 generation, with PHASES parameter and outputs ph, first_half_end, cycle_end. It is reused by the SID/CIA clock-enable logic.
- Arbiter FSM, grant logic and muxes live in the top module.

## Test plan
- Idle read: after reset release, cpu_req=1, cpu_we=0, cpu_addr=0x005, RAM[5]=0x1A5 → cpu_ack at ph=7 of the first full cycle, cpu_rdata=0x1A5, aec high only on ph 4..7.
- Write: cpu_we=1, addr 0x3E7, data 0x1E7 → mem_we high exactly 1 clock at ph=4. A later VIC read of 0x3E7 returns 0x1E7.
- Steal sequence: vic_req=1 at cycle 10 → ba low from cycle 10, ph 0. aec high on ph 4..7 in cycles 10–12 and low all of cycles 13+. vic_rdata updated twice per cycle from cycle 13.
- Grace rules: pending read issued in cycle 10 → no ack until vic_req drops. Pending write in cycle 11 → acked in cycle 11.
- Early release: vic_req drops before cycle 13's ph=0 → return to IDLE, ba=1, aec normal, no STOLEN cycle.
- Reset mid-steal at ph=5 of a STOLEN cycle → next edge ba=1, aec=0, phi0=0, mem_we=0, cpu_ack=0.

Source files
------------

// File: rtl/vic_bus_arbiter_pkg.sv
// Shared definitions for the C64 video/CPU bus: arbiter states, grace length
// and default bus widths.
package c64_bus_pkg;

  localparam int ADDR_WIDTH_DEF = 14;
  localparam int DATA_WIDTH_DEF = 12;

  // CPU half-cycles still granted (writes only) after ba falls.
  localparam logic [1:0] BA_GRACE = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BA_WAIT = 2'd1,
    STOLEN  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vic_bus_arbiter_if.sv
// Shared video bus: VIC request/address, CPU access port and the RAM/ROM side.
// master = arbiter, slave = surrounding system (VIC, CPU, memories).
interface vic_bus_arbiter_if #(
  parameter int ADDR_WIDTH = c64_bus_pkg::ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = c64_bus_pkg::DATA_WIDTH_DEF
);
  logic                  vic_req;
  logic [ADDR_WIDTH-1:0] vic_addr;
  logic [DATA_WIDTH-1:0] vic_rdata;
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ack;
  logic                  phi0;
  logic                  aec;
  logic                  ba;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  vic_req, vic_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vic_rdata, cpu_rdata, cpu_ack, phi0, aec, ba, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output vic_req, vic_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vic_rdata, cpu_rdata, cpu_ack, phi0, aec, ba, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vic_bus_arbiter_phi_phase_gen.sv
// Pixel-clock phase counter and phi0 generator; also feeds SID/CIA clock enables.
// phi0 is registered so it rises on the edge that enters the second half.
module phi_phase_gen #(
  parameter int PHASES = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  output logic [$clog2(PHASES)-1:0] o_ph,
  output logic                      o_phi0,
  output logic                      o_first_half_end,
  output logic                      o_cycle_end
);
  localparam int PH_W = $clog2(PHASES);
  localparam logic [PH_W-1:0] PH_LAST    = PH_W'(PHASES - 1);
  localparam logic [PH_W-1:0] PH_HALF    = PH_W'(PHASES / 2);
  localparam logic [PH_W-1:0] PH_HALF_M1 = PH_W'(PHASES / 2 - 1);

  logic [PH_W-1:0] r_ph;
  logic [PH_W-1:0] w_ph_nxt;
  logic            r_phi0;

  // Next phase with wrap at the end of the phi0 cycle.
  always_comb begin
    if (r_ph == PH_LAST) begin
      w_ph_nxt = '0;
    end else begin
      w_ph_nxt = r_ph + PH_W'(1);
    end
  end

  // Phase and phi0 registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ph   <= '0;
      r_phi0 <= 1'b0;
    end else begin
      r_ph   <= w_ph_nxt;
      r_phi0 <= (w_ph_nxt >= PH_HALF);
    end
  end

  assign o_ph             = r_ph;
  assign o_phi0           = r_phi0;
  assign o_first_half_end = (r_ph == PH_HALF_M1);
  assign o_cycle_end      = (r_ph == PH_LAST);
endmodule

// File: rtl/vic_bus_arbiter.sv
// VIC-II / CPU bus arbiter: phi0 time-multiplexing, BA warning with write grace,
// then AEC-low cycle stealing. Decisions are made on the edge entering a phase.
module vic_bus_arbiter
  import c64_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PHASES     = 8
) (
  input  logic               clk,
  input  logic               reset,
  vic_bus_arbiter_if.master  bus
);
  localparam int PH_W = $clog2(PHASES);
  localparam logic [PH_W-1:0] PH_VIC_CAP = PH_W'(PHASES / 2 - 2);
  localparam logic [PH_W-1:0] PH_LAST_M1 = PH_W'(PHASES - 2);

  logic [PH_W-1:0]       w_ph;
  logic                  w_phi0;
  logic                  w_first_half_end;
  logic                  w_cycle_end;

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [1:0]            r_grace;
  logic [1:0]            w_grace_nxt;
  logic [1:0]            w_grace_dec;

  logic                  r_aec;
  logic                  r_ba;
  logic                  r_mem_we;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_cpu_ack;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_vic_rdata;
  logic                  r_go;
  logic                  r_go_we;

  logic                  w_enter_second;
  logic                  w_enter_last;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [ADDR_WIDTH-1:0] w_mem_addr;

  phi_phase_gen #(.PHASES(PHASES)) u_phase (
    .i_clk            (clk),
    .i_reset          (reset),
    .o_ph             (w_ph),
    .o_phi0           (w_phi0),
    .o_first_half_end (w_first_half_end),
    .o_cycle_end      (w_cycle_end)
  );

  assign w_grace_dec    = r_grace - 2'd1;
  assign w_enter_second = w_phi0 ? !w_cycle_end : w_first_half_end;
  assign w_enter_last   = (w_ph == PH_LAST_M1);
  // Grant is only sampled at first_half_end, where r_state equals next state.
  // BA_WAIT admits writes only: a 6510 halted by RDY still completes writes.
  assign w_wr_ok = bus.cpu_req && bus.cpu_we && (r_state != STOLEN);
  assign w_rd_ok = bus.cpu_req && !bus.cpu_we && (r_state == IDLE);

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_grace <= BA_GRACE;
    end else begin
      r_state <= w_state_nxt;
      r_grace <= w_grace_nxt;
    end
  end

  // Next state: only evaluated on the edge entering ph = 0.
  always_comb begin
    w_state_nxt = r_state;
    w_grace_nxt = r_grace;
    if (w_cycle_end) begin
      case (r_state)
        IDLE: begin
          w_grace_nxt = BA_GRACE;
          if (bus.vic_req) begin
            w_state_nxt = BA_WAIT;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        BA_WAIT: begin
          if (!bus.vic_req) begin
            w_state_nxt = IDLE;
            w_grace_nxt = BA_GRACE;
          end else if (w_grace_dec == 2'd0) begin
            w_state_nxt = STOLEN;
            w_grace_nxt = 2'd0;
          end else begin
            w_state_nxt = BA_WAIT;
            w_grace_nxt = w_grace_dec;
          end
        end
        STOLEN: begin
          w_grace_nxt = BA_GRACE;
          if (bus.vic_req) begin
            w_state_nxt = STOLEN;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_grace_nxt = BA_GRACE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
      w_grace_nxt = r_grace;
    end
  end

  // Bus control outputs, registered for the phase being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_aec       <= 1'b0;
      r_ba        <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_go        <= 1'b0;
      r_go_we     <= 1'b0;
    end else begin
      r_aec       <= w_enter_second && (w_state_nxt != STOLEN);
      r_ba        <= (w_state_nxt == IDLE);
      r_mem_we    <= w_first_half_end && w_wr_ok;
      r_mem_wdata <= bus.cpu_wdata;
      r_cpu_ack   <= w_enter_last && r_go;
      if (w_first_half_end) begin
        r_go    <= w_wr_ok || w_rd_ok;
        r_go_we <= bus.cpu_we;
      end else if (w_cycle_end) begin
        r_go    <= 1'b0;
        r_go_we <= 1'b0;
      end
    end
  end

  // Read-data capture; a stolen cycle gives the VIC a second fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_rdata <= '0;
      r_vic_rdata <= '0;
    end else begin
      if (w_enter_last && r_go && !r_go_we) begin
        r_cpu_rdata <= bus.mem_rdata;
      end
      if ((w_ph == PH_VIC_CAP) || (w_enter_last && (r_state == STOLEN))) begin
        r_vic_rdata <= bus.mem_rdata;
      end
    end
  end

  assign w_mem_addr    = (w_phi0 && (r_state != STOLEN)) ? bus.cpu_addr : bus.vic_addr;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.phi0      = w_phi0;
  assign bus.aec       = r_aec;
  assign bus.ba        = r_ba;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.vic_rdata = r_vic_rdata;
endmodule
